cache_mem_arbiter: RTL and testbench

Shares the single main-memory port between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores. It sits between the two cache fill FSMs and the 4-cycle pipelined main memory. It grants one requester at a time and holds a fill grant for a full 8-beat block. It forwards the granted address and write data to memory and returns `mem_data_valid` only to the granted fill FSM.

---
 rtl/cache_arb_pkg.sv | 15 +
 rtl/cache_mem_arbiter_beat_counter.sv | 29 ++
 rtl/cache_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and sizing for the cache memory-port arbiter.
package cache_arb_pkg;

    localparam int unsigned DEF_BEATS = 8;
    localparam int unsigned CNT_W     = $clog2(DEF_BEATS) + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_I_FILL  = 3'd1,
        ST_D_FILL  = 3'd2,
        ST_D_WRITE = 3'd3,
        ST_DONE    = 3'd4
    } arb_state_e;

endpackage

// File: rtl/cache_mem_arbiter_beat_counter.sv
// beat_counter: small up-counter with synchronous clear and increment enable.
module beat_counter
    import cache_arb_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Clear takes precedence over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the main-memory port between I-cache fills,
// D-cache fills and D-cache write-through stores.
// Optional build macro: ARB_ROUND_ROBIN_EN (I side vs D side alternation).
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BEATS  = DEF_BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_fill_req,
    input  logic [ADDR_W-1:0] i_fill_addr,
    input  logic              d_fill_req,
    input  logic [ADDR_W-1:0] d_fill_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              i_grant,
    output logic              d_grant,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic              d_wr_ack,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_data_valid
);

    localparam int unsigned   CW      = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
    localparam logic [CW-1:0] LAST_C  = CW'(BEATS - 1);

    arb_state_e    state_q;
    logic [CW-1:0] issued;
    logic [CW-1:0] returned;
    logic          fill_act;
    logic          wr_st;
    logic          issue;
    logic          pick_i;

    // Beat counters are held at zero whenever the arbiter is idle.
    beat_counter #(.W(CW)) u_issued (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q == ST_IDLE),
        .inc_i   (issue),
        .count_o (issued)
    );

    beat_counter #(.W(CW)) u_returned (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q == ST_IDLE),
        .inc_i   (fill_act && mem_data_valid),
        .count_o (returned)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;

    // Remember which side was granted last; starts on D so I wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b1;
        end else if (state_q == ST_IDLE && (i_fill_req || d_fill_req || d_wr_req)) begin
            last_d_q <= !pick_i;
        end
    end

    // I side wins when alone, or when tied and D was served last.
    always_comb begin
        pick_i = i_fill_req && (!(d_fill_req || d_wr_req) || last_d_q);
    end
`else
    // Fixed priority: I side only when no D-side request is pending.
    always_comb begin
        pick_i = i_fill_req && !d_fill_req && !d_wr_req;
    end
`endif

    // Arbitration state machine; fills end on the last returned beat, not on a timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_i) begin
                        state_q <= ST_I_FILL;
                    end else if (d_fill_req) begin
                        state_q <= ST_D_FILL;
                    end else if (d_wr_req) begin
                        state_q <= ST_D_WRITE;
                    end
                end
                ST_I_FILL, ST_D_FILL: begin
                    if (mem_data_valid && returned == LAST_C) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_D_WRITE: state_q <= ST_IDLE;
                ST_DONE:    state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Output decode from the registered state plus the beat counters.
    always_comb begin
        i_grant      = (state_q == ST_I_FILL);
        d_grant      = (state_q == ST_D_FILL);
        wr_st        = (state_q == ST_D_WRITE);
        fill_act     = i_grant || d_grant;
        issue        = fill_act && (issued < BEATS_C);
        mem_enable   = issue || wr_st;
        mem_wr       = wr_st;
        d_wr_ack     = wr_st;
        i_data_valid = i_grant && mem_data_valid;
        d_data_valid = d_grant && mem_data_valid;
        mem_data_in  = d_wr_data;
        if (i_grant) begin
            mem_addr = i_fill_addr;
        end else if (d_grant) begin
            mem_addr = d_fill_addr;
        end else begin
            mem_addr = d_wr_addr;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter with a 4-cycle pipelined memory model.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_fill_req = 1'b0;
    logic [15:0] i_fill_addr = '0;
    logic        d_fill_req = 1'b0;
    logic [15:0] d_fill_addr = '0;
    logic        d_wr_req = 1'b0;
    logic [15:0] d_wr_addr = '0;
    logic [15:0] d_wr_data = '0;
    logic        i_grant, d_grant, i_data_valid, d_data_valid, d_wr_ack;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in;
    logic        mem_data_valid;
    logic [3:0]  pipe = '0;

    int checks = 0;
    int errors = 0;

    // {i_grant, d_grant, mem_enable, mem_wr, i_data_valid, d_data_valid, d_wr_ack}
    logic [6:0] obs;
    logic [6:0] exp_v;
    logic [15:0] exp_a;

    assign obs = {i_grant, d_grant, mem_enable, mem_wr, i_data_valid, d_data_valid, d_wr_ack};

    always #5 clk = ~clk;

    // Memory: every read issue returns one valid four cycles later.
    always @(posedge clk) pipe <= {pipe[2:0], mem_enable & ~mem_wr};
    assign mem_data_valid = pipe[3];

    cache_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BEATS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_fill_req     (i_fill_req),
        .i_fill_addr    (i_fill_addr),
        .d_fill_req     (d_fill_req),
        .d_fill_addr    (d_fill_addr),
        .d_wr_req       (d_wr_req),
        .d_wr_addr      (d_wr_addr),
        .d_wr_data      (d_wr_data),
        .i_grant        (i_grant),
        .d_grant        (d_grant),
        .i_data_valid   (i_data_valid),
        .d_data_valid   (d_data_valid),
        .d_wr_ack       (d_wr_ack),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want %b", obs, 7'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_idle got %b want %b", obs, 7'b0);
        end
    endtask

    task automatic test_i_fill();
        i_fill_req  = 1'b1;
        i_fill_addr = 16'h0040;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            exp_v = {1'(c <= 12), 1'b0, 1'(c <= 8), 1'b0, 1'(c >= 5 && c <= 12), 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL i_fill cycle %0d got %b want %b", c, obs, exp_v);
            end
            if (c <= 8) begin
                exp_a = 16'(16'h0040 + 2 * (c - 1));
                checks++;
                if (mem_addr !== exp_a) begin
                    errors++;
                    $display("FAIL i_fill_addr cycle %0d got %h want %h", c, mem_addr, exp_a);
                end
                i_fill_addr = i_fill_addr + 16'd2;
            end
            if (c == 13) i_fill_req = 1'b0;
        end
    endtask

    task automatic test_store();
        d_wr_req  = 1'b1;
        d_wr_addr = 16'h1000;
        d_wr_data = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (obs !== 7'b0011001) begin
            errors++;
            $display("FAIL store_strobe got %b want %b", obs, 7'b0011001);
        end
        checks++;
        if (mem_addr !== 16'h1000 || mem_data_in !== 16'hBEEF) begin
            errors++;
            $display("FAIL store_addr_data got %h/%h want 1000/beef", mem_addr, mem_data_in);
        end
        d_wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL store_after got %b want %b", obs, 7'b0);
        end
    endtask

    task automatic test_back_to_back();
        d_wr_req  = 1'b1;
        d_wr_addr = 16'h1002;
        d_wr_data = 16'h1234;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            exp_v = (c % 2 == 1 && c <= 5) ? 7'b0011001 : 7'b0;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL back_to_back cycle %0d got %b want %b", c, obs, exp_v);
            end
            if (c == 5) d_wr_req = 1'b0;
        end
    endtask

    task automatic test_store_during_fill();
        d_fill_req  = 1'b1;
        d_fill_addr = 16'h2000;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            exp_v = {1'b0, 1'(c <= 12), 1'(c <= 8 || c == 15), 1'(c == 15),
                     1'b0, 1'(c >= 5 && c <= 12), 1'(c == 15)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL store_during_fill cycle %0d got %b want %b", c, obs, exp_v);
            end
            if (c <= 8 || c == 15) begin
                exp_a = (c == 15) ? 16'h1000 : 16'h2000;
                checks++;
                if (mem_addr !== exp_a) begin
                    errors++;
                    $display("FAIL store_during_fill_addr cycle %0d got %h want %h", c, mem_addr, exp_a);
                end
            end
            if (c == 2) begin
                d_wr_req  = 1'b1;
                d_wr_addr = 16'h1000;
                d_wr_data = 16'hBEEF;
            end
            if (c == 13) d_fill_req = 1'b0;
            if (c == 15) d_wr_req = 1'b0;
        end
    endtask

    task automatic test_contention();
        logic first_is_d;
        logic fg, sg, fv, sv, en, dg;
`ifdef ARB_ROUND_ROBIN_EN
        first_is_d = 1'b0;
`else
        first_is_d = 1'b1;
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_fill_req  = 1'b1;
        i_fill_addr = 16'h0040;
        d_fill_req  = 1'b1;
        d_fill_addr = 16'h2000;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            fg = (c <= 12);
            sg = (c >= 15 && c <= 26);
            fv = (c >= 5 && c <= 12);
            sv = (c >= 19 && c <= 26);
            en = (c <= 8) || (c >= 15 && c <= 22);
            dg = first_is_d ? fg : sg;
            exp_v = first_is_d ? {sg, fg, en, 1'b0, sv, fv, 1'b0}
                               : {fg, sg, en, 1'b0, fv, sv, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL contention cycle %0d got %b want %b", c, obs, exp_v);
            end
            if (en) begin
                exp_a = dg ? 16'h2000 : 16'h0040;
                checks++;
                if (mem_addr !== exp_a) begin
                    errors++;
                    $display("FAIL contention_addr cycle %0d got %h want %h", c, mem_addr, exp_a);
                end
            end
            if (c == 13) begin
                if (first_is_d) d_fill_req = 1'b0;
                else            i_fill_req = 1'b0;
            end
            if (c == 27) begin
                i_fill_req = 1'b0;
                d_fill_req = 1'b0;
            end
        end
    endtask

    task automatic test_hold_and_reset();
        i_fill_req  = 1'b1;
        i_fill_addr = 16'h0040;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            exp_v = {1'(c <= 12 || c >= 15), 1'b0, 1'(c <= 8 || c >= 15), 1'b0,
                     1'((c >= 5 && c <= 12) || c >= 19), 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL hold_through_done cycle %0d got %b want %b", c, obs, exp_v);
            end
        end
        // Three beats have been counted; reset lands with the rest still in flight.
        @(negedge clk);
        rst = 1'b1;
        i_fill_req = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_fill got %b want %b", obs, 7'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 23; c <= 28; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL post_reset_drop cycle %0d got %b want %b", c, obs, 7'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_fill();
        test_store();
        test_back_to_back();
        test_store_during_fill();
        test_contention();
        test_hold_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
